// File: rtl/ssp_pkg.sv
// Shared decode helpers for the 2-way superscalar pipeline: opcode values,
// instruction field positions and operand/destination extraction.
package ssp_pkg;

    // Opcode map (op field, bits [31:26])
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_MUL  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h09;
    localparam logic [5:0] OP_ORI  = 6'h0A;
    localparam logic [5:0] OP_LW   = 6'h10;
    localparam logic [5:0] OP_SW   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h14;
    localparam logic [5:0] OP_BNE  = 6'h15;
    localparam logic [5:0] OP_J    = 6'h18;
    localparam logic [5:0] OP_JAL  = 6'h19;
    localparam logic [5:0] OP_NOP  = 6'h3F;

    // Field bit ranges
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS1_HI = 25;
    localparam int RS1_LO = 21;
    localparam int RS2_HI = 20;
    localparam int RS2_LO = 16;
    localparam int RDR_HI = 15;   // R-type destination
    localparam int RDR_LO = 11;
    localparam int RDI_HI = 20;   // I-type / LW destination
    localparam int RDI_LO = 16;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [3:0] {
        CL_ALU, CL_MUL, CL_IMM, CL_LD, CL_ST, CL_BR, CL_J, CL_JAL, CL_NOP
    } op_class_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
    } srcs_t;

    // Unlisted opcodes decode like an I-type op so they still honour hazards.
    function automatic op_class_e class_of(input logic [31:0] instr);
        case (instr[OP_HI:OP_LO])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return CL_ALU;
            OP_MUL:                                return CL_MUL;
            OP_ADDI, OP_ANDI, OP_ORI:              return CL_IMM;
            OP_LW:                                 return CL_LD;
            OP_SW:                                 return CL_ST;
            OP_BEQ, OP_BNE:                        return CL_BR;
            OP_J:                                  return CL_J;
            OP_JAL:                                return CL_JAL;
            OP_NOP:                                return CL_NOP;
            default:                               return CL_IMM;
        endcase
    endfunction

    function automatic logic is_mem(input logic [31:0] instr);
        return (class_of(instr) == CL_LD) || (class_of(instr) == CL_ST);
    endfunction

    function automatic logic is_mul(input logic [31:0] instr);
        return class_of(instr) == CL_MUL;
    endfunction

    function automatic logic is_ctrl(input logic [31:0] instr);
        return (class_of(instr) == CL_BR) || (class_of(instr) == CL_J) ||
               (class_of(instr) == CL_JAL);
    endfunction

    function automatic logic is_nop(input logic [31:0] instr);
        return class_of(instr) == CL_NOP;
    endfunction

    // Destination register; 0 means "writes nothing".
    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        case (class_of(instr))
            CL_ALU, CL_MUL: return instr[RDR_HI:RDR_LO];
            CL_IMM, CL_LD:  return instr[RDI_HI:RDI_LO];
            CL_JAL:         return LINK_REG;
            default:        return 5'd0;
        endcase
    endfunction

    function automatic logic has_rd(input logic [31:0] instr);
        return rd_of(instr) != 5'd0;
    endfunction

    // Source registers; an absent operand reads as R0, which is never busy.
    function automatic srcs_t srcs_of(input logic [31:0] instr);
        srcs_t s;
        s = '0;
        case (class_of(instr))
            CL_ALU, CL_MUL, CL_ST, CL_BR: begin
                s.rs1 = instr[RS1_HI:RS1_LO];
                s.rs2 = instr[RS2_HI:RS2_LO];
            end
            CL_IMM, CL_LD: s.rs1 = instr[RS1_HI:RS1_LO];
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sb_scoreboard.sv
// Per-register busy tracker for multi-cycle producers (MUL, LW).
// Each register owns a down-counter loaded with the producer latency; the
// register is busy while its counter is non-zero. R0 is never busy.
module sb_scoreboard #(
    parameter  int NREG = 32,
    parameter  int CW   = 3,
    localparam int RW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        set_en,
    input  logic [2*RW-1:0]   set_reg,
    input  logic [2*CW-1:0]   set_lat,
    input  logic [6*RW-1:0]   rd_reg,
    output logic [5:0]        rd_busy
);

    logic [NREG-1:0] busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign busy_vec[gi] = 1'b0;
            end else begin : g_cnt
                logic [CW-1:0] cnt_reg;
                logic [CW-1:0] cnt_next;
                logic          hit0;
                logic          hit1;

                assign hit0 = set_en[0] && (set_reg[0 +: RW]  == RW'(gi));
                assign hit1 = set_en[1] && (set_reg[RW +: RW] == RW'(gi));

                // A fresh producer reloads the counter; otherwise count down to 0.
                always_comb begin
                    cnt_next = cnt_reg;
                    if (hit1)
                        cnt_next = set_lat[CW +: CW];
                    else if (hit0)
                        cnt_next = set_lat[0 +: CW];
                    else if (cnt_reg != '0)
                        cnt_next = cnt_reg - 1'b1;
                end

                // Counter register.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)
                        cnt_reg <= '0;
                    else
                        cnt_reg <= cnt_next;
                end

                assign busy_vec[gi] = |cnt_reg;
            end
        end

        for (gi = 0; gi < 6; gi++) begin : g_rd
            assign rd_busy[gi] = busy_vec[rd_reg[gi*RW +: RW]];
        end
    endgenerate

endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-wide issue controller: pairs, splits or stalls each fetched bundle
// based on intra-bundle hazards, structural limits and the scoreboard.
module dual_issue_scheduler
    import ssp_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int MUL_LAT = 3,
    parameter int LD_LAT  = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_instr0,
    input  logic [31:0]      in_instr1,
    output logic             in_ready,
    input  logic             flush,
    output logic             iss0_valid,
    output logic [31:0]      iss0_instr,
    output logic             iss1_valid,
    output logic [31:0]      iss1_instr,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MAX_LAT = (MUL_LAT > LD_LAT) ? MUL_LAT : LD_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [31:0]      hold_reg, hold_next;
    logic             v0_reg, v0_next, v1_reg, v1_next;
    logic [31:0]      i0_reg, i0_next, i1_reg, i1_next;
    logic [CNT_W-1:0] dual_reg, stall_reg;
    logic             dual_inc, stall_inc, ready_c;

    // Candidate for lane0 is the parked instruction when one is held.
    logic [31:0] cand0;
    srcs_t       src0, src1;
    logic [4:0]  rd0, rd1;
    logic [5:0]  busy;
    logic        blocked0, blocked1, raw_waw, pairable;

    logic [1:0]      set_en;
    logic [9:0]      set_reg;
    logic [2*CW-1:0] set_lat;

    assign cand0 = (state_reg == ST_HELD) ? hold_reg : in_instr0;
    assign src0  = srcs_of(cand0);
    assign src1  = srcs_of(in_instr1);
    assign rd0   = rd_of(cand0);
    assign rd1   = rd_of(in_instr1);

    sb_scoreboard #(.NREG(NREG), .CW(CW)) u_sb (
        .clk     (clk1),
        .rst     (reset),
        .set_en  (set_en),
        .set_reg (set_reg),
        .set_lat (set_lat),
        .rd_reg  ({rd1, src1.rs2, src1.rs1, rd0, src0.rs2, src0.rs1}),
        .rd_busy (busy)
    );

    assign blocked0 = |busy[2:0];
    assign blocked1 = |busy[5:3];
    assign raw_waw  = (rd0 != 5'd0) &&
                      ((src1.rs1 == rd0) || (src1.rs2 == rd0) || (rd1 == rd0));
    assign pairable = !is_ctrl(cand0) && !raw_waw &&
                      !(is_mem(cand0) && is_mem(in_instr1)) &&
                      !(is_mul(cand0) && is_mul(in_instr1)) &&
                      !blocked1;

    function automatic logic tracked(input logic [31:0] instr);
        return (is_mul(instr) || class_of(instr) == CL_LD) && has_rd(instr);
    endfunction

    function automatic logic [CW-1:0] lat_of(input logic [31:0] instr);
        return is_mul(instr) ? CW'(MUL_LAT) : CW'(LD_LAT);
    endfunction

    // Issue decision: flush beats everything, then a held instruction, then a new bundle.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        v0_next    = 1'b0;
        v1_next    = 1'b0;
        i0_next    = i0_reg;
        i1_next    = i1_reg;
        dual_inc   = 1'b0;
        stall_inc  = 1'b0;
        ready_c    = 1'b0;
        set_en     = 2'b00;
        set_reg    = {rd_of(in_instr1), rd0};
        set_lat    = {lat_of(in_instr1), lat_of(cand0)};
        if (flush) begin
            state_next = ST_EMPTY;
            hold_next  = '0;
        end else if (state_reg == ST_HELD) begin
            if (blocked0) begin
                stall_inc = 1'b1;
            end else begin
                v0_next    = 1'b1;
                i0_next    = hold_reg;
                set_en[0]  = tracked(hold_reg);
                state_next = ST_EMPTY;
                hold_next  = '0;
            end
        end else if (in_valid) begin
            if (!is_nop(in_instr0) && blocked0) begin
                stall_inc = 1'b1;
            end else begin
                ready_c = 1'b1;
                if (!is_nop(in_instr0)) begin
                    v0_next   = 1'b1;
                    i0_next   = in_instr0;
                    set_en[0] = tracked(in_instr0);
                end
                if (!is_nop(in_instr1)) begin
                    if (pairable) begin
                        v1_next   = 1'b1;
                        i1_next   = in_instr1;
                        set_en[1] = tracked(in_instr1);
                        dual_inc  = !is_nop(in_instr0);
                    end else begin
                        hold_next  = in_instr1;
                        state_next = ST_HELD;
                    end
                end
            end
        end
    end

    // Pipeline state, registered issue outputs and performance counters.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_reg <= ST_EMPTY;
            hold_reg  <= '0;
            v0_reg    <= 1'b0;
            v1_reg    <= 1'b0;
            i0_reg    <= '0;
            i1_reg    <= '0;
            dual_reg  <= '0;
            stall_reg <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            v0_reg    <= v0_next;
            v1_reg    <= v1_next;
            i0_reg    <= i0_next;
            i1_reg    <= i1_next;
            if (dual_inc)
                dual_reg <= dual_reg + 1'b1;
            if (stall_inc)
                stall_reg <= stall_reg + 1'b1;
        end
    end

    // Reset forces the handshake low so nothing appears consumed mid-reset.
    assign in_ready   = ready_c & ~reset;
    assign iss0_valid = v0_reg;
    assign iss0_instr = i0_reg;
    assign iss1_valid = v1_reg;
    assign iss1_instr = i1_reg;
    assign dual_cnt   = dual_reg;
    assign stall_cnt  = stall_reg;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed scenarios followed by
// random bundles, all compared against a time-stamp based reference model.
module tb_dual_issue_scheduler;
    import ssp_pkg::*;

    logic        clk1 = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr0 = '0;
    logic [31:0] in_instr1 = '0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic        iss0_valid, iss1_valid;
    logic [31:0] iss0_instr, iss1_instr;
    logic [31:0] dual_cnt, stall_cnt;

    always #5 clk1 = ~clk1;

    dual_issue_scheduler #(.NREG(32), .MUL_LAT(3), .LD_LAT(2), .CNT_W(32)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_instr0  (in_instr0),
        .in_instr1  (in_instr1),
        .in_ready   (in_ready),
        .flush      (flush),
        .iss0_valid (iss0_valid),
        .iss0_instr (iss0_instr),
        .iss1_valid (iss1_valid),
        .iss1_instr (iss1_instr),
        .dual_cnt   (dual_cnt),
        .stall_cnt  (stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a register is busy while the current cycle number is
    // below the cycle at which its producer's result becomes available.
    localparam int K_ALU = 0, K_MUL = 1, K_IMM = 2, K_LD = 3, K_ST = 4,
                   K_BR = 5, K_J = 6, K_JAL = 7, K_NOP = 8;
    int          cyc;
    int          tcyc;
    int          free_at [32];
    bit          m_held;
    logic [31:0] m_hold, m_i0, m_i1, m_dual, m_stall;
    logic        m_v0, m_v1;
    bit          p_ready, p_v0, p_v1, p_held, p_dual, p_stall;
    logic [31:0] p_i0, p_i1, p_hold;
    int          p_set_r [2];
    int          p_set_lat [2];
    bit          last_ready;

    function automatic int kind(input logic [31:0] i);
        case (i[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return K_ALU;
            OP_MUL:                  return K_MUL;
            OP_ADDI, OP_ANDI, OP_ORI: return K_IMM;
            OP_LW:                   return K_LD;
            OP_SW:                   return K_ST;
            OP_BEQ, OP_BNE:          return K_BR;
            OP_J:                    return K_J;
            OP_JAL:                  return K_JAL;
            default:                 return K_NOP;
        endcase
    endfunction

    function automatic int dest(input logic [31:0] i);
        case (kind(i))
            K_ALU, K_MUL: return int'(i[15:11]);
            K_IMM, K_LD:  return int'(i[20:16]);
            K_JAL:        return 31;
            default:      return 0;
        endcase
    endfunction

    function automatic bit reads(input logic [31:0] i, input int r);
        if (r == 0) return 0;
        case (kind(i))
            K_ALU, K_MUL, K_ST, K_BR: return (int'(i[25:21]) == r) || (int'(i[20:16]) == r);
            K_IMM, K_LD:              return int'(i[25:21]) == r;
            default:                  return 0;
        endcase
    endfunction

    function automatic bit blocked(input logic [31:0] i);
        for (int r = 1; r < 32; r++)
            if ((reads(i, r) || dest(i) == r) && cyc < free_at[r]) return 1;
        return 0;
    endfunction

    function automatic int lat(input logic [31:0] i);
        if (kind(i) == K_MUL) return 3;
        if (kind(i) == K_LD)  return 2;
        return 0;
    endfunction

    function automatic bit is_mem_k(input int k);
        return (k == K_LD) || (k == K_ST);
    endfunction

    task automatic model_reset();
        cyc = 0;
        foreach (free_at[r]) free_at[r] = 0;
        m_held = 0; m_hold = '0;
        m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0;
        m_dual = '0; m_stall = '0;
    endtask

    task automatic note_issue(input int lane, input logic [31:0] i);
        if (lat(i) > 0 && dest(i) != 0) begin
            p_set_r[lane]   = dest(i);
            p_set_lat[lane] = lat(i);
        end
    endtask

    task automatic decide();
        logic [31:0] a, b;
        int da;
        bit pair;
        p_ready = 0; p_v0 = 0; p_v1 = 0; p_dual = 0; p_stall = 0;
        p_i0 = m_i0; p_i1 = m_i1; p_held = m_held; p_hold = m_hold;
        p_set_r[0] = 0; p_set_r[1] = 0; p_set_lat[0] = 0; p_set_lat[1] = 0;
        a = in_instr0; b = in_instr1;
        if (flush) begin
            p_held = 0; p_hold = '0;
        end else if (m_held) begin
            if (blocked(m_hold)) p_stall = 1;
            else begin
                p_v0 = 1; p_i0 = m_hold; note_issue(0, m_hold);
                p_held = 0; p_hold = '0;
            end
        end else if (in_valid) begin
            if (kind(a) != K_NOP && blocked(a)) p_stall = 1;
            else begin
                p_ready = 1;
                if (kind(a) != K_NOP) begin
                    p_v0 = 1; p_i0 = a; note_issue(0, a);
                end
                if (kind(b) != K_NOP) begin
                    da = dest(a);
                    pair = !(kind(a) inside {K_BR, K_J, K_JAL}) &&
                           !(da != 0 && (reads(b, da) || dest(b) == da)) &&
                           !(is_mem_k(kind(a)) && is_mem_k(kind(b))) &&
                           !(kind(a) == K_MUL && kind(b) == K_MUL) &&
                           !blocked(b);
                    if (pair) begin
                        p_v1 = 1; p_i1 = b; note_issue(1, b);
                        p_dual = p_v0;
                    end else begin
                        p_held = 1; p_hold = b;
                    end
                end
            end
        end
    endtask

    task automatic commit();
        for (int j = 0; j < 2; j++)
            if (p_set_r[j] != 0) free_at[p_set_r[j]] = cyc + p_set_lat[j] + 1;
        cyc++;
        m_v0 = p_v0; m_v1 = p_v1; m_i0 = p_i0; m_i1 = p_i1;
        m_held = p_held; m_hold = p_hold;
        m_dual  = m_dual + 32'(p_dual);
        m_stall = m_stall + 32'(p_stall);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: decide/check handshake mid-cycle, then check registered outputs.
    task automatic cycle();
        @(negedge clk1);
        decide();
        chk("in_ready", 32'(in_ready), 32'(p_ready));
        last_ready = p_ready;
        @(posedge clk1);
        #1;
        commit();
        tcyc++;
        chk("iss0_valid", 32'(iss0_valid), 32'(m_v0));
        chk("iss1_valid", 32'(iss1_valid), 32'(m_v1));
        chk("iss0_instr", iss0_instr, m_i0);
        chk("iss1_instr", iss1_instr, m_i1);
        chk("dual_cnt", dual_cnt, m_dual);
        chk("stall_cnt", stall_cnt, m_stall);
        $display("cyc %0d rdy=%0b v0=%0b i0=%h v1=%0b i1=%h dual=%0d stall=%0d",
                 tcyc, last_ready, iss0_valid, iss0_instr, iss1_valid, iss1_instr,
                 dual_cnt, stall_cnt);
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b, input bit f);
        in_valid = v; in_instr0 = a; in_instr1 = b; flush = f;
    endtask

    task automatic idle(input int n);
        drive(0, '0, '0, 0);
        repeat (n) cycle();
    endtask

    function automatic logic [31:0] r3(input logic [5:0] op, input int rd, input int rs1, input int rs2);
        return {op, 5'(rs1), 5'(rs2), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rd, input int rs1, input int imm);
        return {op, 5'(rs1), 5'(rd), 16'(imm)};
    endfunction

    function automatic logic [31:0] rs(input logic [5:0] op, input int rs1, input int rs2, input int imm);
        return {op, 5'(rs1), 5'(rs2), 16'(imm)};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0] op;
        case ($urandom_range(0, 15))
            0: op = OP_ADD;   1: op = OP_SUB;   2: op = OP_AND;   3: op = OP_XOR;
            4, 5: op = OP_MUL; 6: op = OP_ADDI; 7, 8: op = OP_LW; 9: op = OP_SW;
            10: op = OP_BEQ;  11: op = OP_BNE;  12: op = OP_J;    13: op = OP_JAL;
            14: op = OP_ORI;
            default: op = OP_NOP;
        endcase
        return {op, 2'b0, 3'($urandom_range(0, 7)), 2'b0, 3'($urandom_range(0, 7)),
                2'b0, 3'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    logic [31:0] nop_i, add_i, sub_i, mul_i, t0, t1;
    int          t_mul, t_add, stall_base;
    bit          need_new, v, f;

    initial begin
        nop_i = {OP_NOP, 26'd0};
        tcyc = 0;
        model_reset();

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_v0", 32'(iss0_valid), 32'd0);
        chk("rst_i0", iss0_instr, 32'd0);
        chk("rst_dual", dual_cnt, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        @(posedge clk1); @(posedge clk1); #1;
        reset = 1'b0;

        // Independent pair issues together.
        add_i = r3(OP_ADD, 20, 10, 1);
        sub_i = r3(OP_SUB, 21, 3, 2);
        drive(1, add_i, sub_i, 0); cycle();
        chk("tp_pair_i0", iss0_instr, add_i);
        chk("tp_pair_i1", iss1_instr, sub_i);
        chk("tp_pair_dual", dual_cnt, 32'd1);
        idle(1);

        // RAW inside the bundle: slot1 parked, issues the next cycle.
        sub_i = r3(OP_SUB, 21, 20, 2);
        drive(1, add_i, sub_i, 0); cycle();
        chk("tp_raw_v1", 32'(iss1_valid), 32'd0);
        drive(1, r3(OP_ADD, 1, 2, 3), r3(OP_ADD, 4, 5, 6), 0); cycle();
        chk("tp_raw_held_ready", 32'(last_ready), 32'd0);
        chk("tp_raw_i0", iss0_instr, sub_i);
        cycle();
        idle(2);

        // Single memory port and single multiplier.
        drive(1, ri(OP_LW, 5, 1, 0), rs(OP_SW, 2, 6, 4), 0); cycle(); cycle();
        idle(3);
        drive(1, r3(OP_MUL, 7, 8, 9), r3(OP_MUL, 13, 11, 12), 0); cycle(); cycle();
        idle(4);

        // MUL result latency: dependent ADD appears exactly 4 cycles later.
        mul_i = r3(OP_MUL, 22, 4, 5);
        add_i = r3(OP_ADD, 23, 22, 1);
        drive(1, mul_i, nop_i, 0); cycle();
        t_mul = (iss0_valid && iss0_instr == mul_i) ? tcyc : -100;
        stall_base = int'(stall_cnt);
        t_add = -1000;
        drive(1, add_i, nop_i, 0);
        for (int k = 0; k < 10 && t_add < 0; k++) begin
            cycle();
            if (iss0_valid && iss0_instr == add_i) t_add = tcyc;
            if (last_ready) drive(0, '0, '0, 0);
        end
        chk("tp_mul_gap", 32'(t_add - t_mul), 32'd4);
        chk("tp_mul_stalls", 32'(int'(stall_cnt) - stall_base), 32'd3);
        idle(2);

        // Branch in slot0 never pairs.
        t0 = rs(OP_BEQ, 1, 2, 8);
        t1 = r3(OP_ADD, 20, 10, 1);
        drive(1, t0, t1, 0); cycle();
        chk("tp_br_v1", 32'(iss1_valid), 32'd0);
        drive(0, '0, '0, 0); cycle();
        chk("tp_br_add", iss0_instr, t1);
        idle(1);

        // Flush while holding: held instruction is dropped.
        drive(1, r3(OP_ADD, 20, 10, 1), r3(OP_SUB, 21, 20, 2), 0); cycle();
        drive(0, '0, '0, 1); cycle();
        chk("tp_flush_v0", 32'(iss0_valid), 32'd0);
        drive(1, r3(OP_ADD, 1, 2, 3), r3(OP_OR, 4, 5, 6), 0); cycle();
        chk("tp_flush_ready", 32'(last_ready), 32'd1);
        idle(4);

        // Reset in the middle of a stall clears outputs without a clock edge.
        drive(1, mul_i, nop_i, 0); cycle();
        drive(1, add_i, nop_i, 0); cycle();
        @(negedge clk1);
        reset = 1'b1;
        #1;
        chk("tp_rst_ready", 32'(in_ready), 32'd0);
        chk("tp_rst_v0", 32'(iss0_valid), 32'd0);
        chk("tp_rst_i0", iss0_instr, 32'd0);
        chk("tp_rst_v1", 32'(iss1_valid), 32'd0);
        chk("tp_rst_dual", dual_cnt, 32'd0);
        chk("tp_rst_stall", stall_cnt, 32'd0);
        @(posedge clk1); #1;
        reset = 1'b0;
        model_reset();
        idle(1);

        // Random bundles held until consumed, with occasional flushes.
        need_new = 1;
        t0 = '0; t1 = '0; v = 0;
        for (int n = 0; n < 400; n++) begin
            if (need_new) begin
                v  = ($urandom_range(0, 3) != 0);
                t0 = rnd_instr();
                t1 = rnd_instr();
            end
            f = ($urandom_range(0, 19) == 0);
            drive(v, t0, t1, f);
            cycle();
            need_new = last_ready || f || !v;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
